s_port_arbiter_ctrl: RTL and testbench
======================================

Name: s_port_arbiter_ctrl

Overview:
- Sequencing controller for the south output port of a mesh router.
- Detects which of the north, west, east and local input buffers hold a head flit routed south, grants the port round-robin, and holds the grant (wormhole lock) until that packet's tail flit crosses.
- Gates each flit transfer on downstream credits and drives the crossbar select.
- Emits the order-rotate pulse consumed by the south round-robin priority registers.

Parameters:
- S_ADDR, 3'd1, nexthop code meaning "route to south".
- CREDITS, 4, downstream south input-buffer depth in flits; sets the credit counter reset value.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- n_req_i, w_req_i, e_req_i, l_req_i  input  1 each  head flit valid in that input buffer.
- n_nexthop_addr_i, w_nexthop_addr_i, e_nexthop_addr_i, l_nexthop_addr_i  input  3 each  nexthop code of that head flit.
- n_tail_i, w_tail_i, e_tail_i, l_tail_i  input  1 each  head flit is the packet tail.
- s_credit_return_i  input  1  downstream freed one slot this cycle.
- s_grant_n_o, s_grant_w_o, s_grant_e_o, s_grant_l_o  output  1 each  registered one-hot lock owner.
- s_xbar_sel_o  output  3  crossbar source: 0 none, 1 n, 2 w, 3 e, 4 l.
- s_flit_valid_o  output  1  a flit crosses to south this cycle; the owner pops its buffer.
- rr_change_order_o  output  1  one-cycle rotate pulse to the rr registers.
- s_credits_o  output  CW  current credit count.
- s_busy_o  output  1  state is LOCKED.

Behaviour:
- Desire: desire_x = x_req_i && (x_nexthop_addr_i == S_ADDR), for x in {n, w, e, l}.
- Reset (reset low, asynchronous):
  - state IDLE; rr pointer 0 (n highest priority); credits = CREDITS.
  - All grants 0, s_xbar_sel_o 0, s_flit_valid_o 0, rr_change_order_o 0, s_busy_o 0.
- Priority order: cyclic n(0), w(1), e(2), l(3), starting at the rr pointer. The winner is the first input with desire set.
- IDLE:
  - Grants 0, sel 0, flit_valid 0.
  - If any desire and credits > 0: register the winner as owner, go to LOCKED. Grant and sel are valid from the next cycle.
  - If credits == 0: no arbitration; stay IDLE.
- LOCKED:
  - s_flit_valid_o = owner_req && (credits > 0), combinational from the current inputs.
  - Nexthop inputs are ignored; only the owner's req and tail are used.
  - If the owner deasserts req: lock held, no transfer, no timeout.
  - Non-owner requests have no effect.
- Packet end: s_flit_valid_o && owner_tail in cycle t causes, at cycle t+1:
  - state IDLE, grants 0, sel 0;
  - rr pointer = (owner + 1) mod 4;
  - rr_change_order_o high for exactly cycle t+1.
  - Re-arbitration happens in cycle t+1, so the next grant appears in t+2.
- Latency: desire in cycle 0 (IDLE) gives grant/sel at cycle 1 and first transfer in cycle 1 if credits > 0. A single-flit packet occupies 2 cycles from IDLE.
- Credit counter:
  - next = credits - s_flit_valid_o + s_credit_return_i.
  - Transfer and return in the same cycle leave the count unchanged.
  - A return while credits == CREDITS and no transfer saturates at CREDITS (the return is dropped).
  - The count never underflows, because transfers require credits > 0.
- Simultaneous events: a tail transfer in the same cycle as credits reaching 0 still ends the packet normally. An IDLE arbitration in a cycle where credits == 0 is suppressed, even if a return arrives in that cycle; the grant waits one cycle.
- Reset during LOCKED: immediate return to IDLE with the reset values above. Upstream owns flit recovery.

Test Plan:
- Single requester: reset, then w_req_i=1, w_nexthop=1, w_tail=1 -> cycle 1: s_grant_w_o=1, sel=2, flit_valid=1; cycle 2: grants 0, rr_change_order_o=1, credits=3, pointer=2 (e).
- Round-robin: n, w, e, l all request south with 1-flit packets, no credit returns, CREDITS=4 -> grant order n, w, e, l, one packet every 2 cycles; credits end at 0; four rotate pulses.
- Wormhole lock: e sends a 3-flit packet (tail on the 3rd) while n requests south throughout -> sel stays 3 for 3 transfers; n is granted only 2 cycles after e's tail.
- Credit stall: credits drained to 0 mid-packet -> flit_valid=0 and grant held; pulse s_credit_return_i for 1 cycle -> exactly one flit transfers the following cycle.
- Non-south filter and saturation: l_req_i=1 with nexthop=3'd2 -> no grant ever. s_credit_return_i held high at credits=4 -> s_credits_o stays 4.
- Async reset mid-packet: assert reset low between clock edges while LOCKED -> all outputs 0 and credits=4 immediately, without waiting for a clock edge; after release, n is the highest priority again.

Source files
------------

// File: rtl/s_port_arbiter_ctrl.sv
// South output port controller for a mesh router: round-robin arbitration
// over the n/w/e/l input buffers, wormhole lock until the tail flit,
// credit-gated flit transfer, crossbar select and rr rotate pulse.
module s_port_arbiter_ctrl #(
  parameter logic [2:0]  S_ADDR  = 3'd1,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          n_req_i,
  input  logic          w_req_i,
  input  logic          e_req_i,
  input  logic          l_req_i,
  input  logic [2:0]    n_nexthop_addr_i,
  input  logic [2:0]    w_nexthop_addr_i,
  input  logic [2:0]    e_nexthop_addr_i,
  input  logic [2:0]    l_nexthop_addr_i,
  input  logic          n_tail_i,
  input  logic          w_tail_i,
  input  logic          e_tail_i,
  input  logic          l_tail_i,
  input  logic          s_credit_return_i,
  output logic          s_grant_n_o,
  output logic          s_grant_w_o,
  output logic          s_grant_e_o,
  output logic          s_grant_l_o,
  output logic [2:0]    s_xbar_sel_o,
  output logic          s_flit_valid_o,
  output logic          rr_change_order_o,
  output logic [CW-1:0] s_credits_o,
  output logic          s_busy_o
);

  localparam logic [CW-1:0] L_CREDITS = CW'(CREDITS);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_credits, w_credits_nxt;
  logic          r_rr_pulse, w_rr_pulse_nxt;

  logic [3:0]    w_req, w_tail, w_desire;
  logic [1:0]    w_winner, w_idx;
  logic          w_winner_found;
  logic          w_has_credit, w_locked, w_flit_valid, w_pkt_end;

  // Input vectors indexed n=0, w=1, e=2, l=3
  assign w_req  = {l_req_i, e_req_i, w_req_i, n_req_i};
  assign w_tail = {l_tail_i, e_tail_i, w_tail_i, n_tail_i};
  assign w_desire = {l_req_i && (l_nexthop_addr_i == S_ADDR),
                     e_req_i && (e_nexthop_addr_i == S_ADDR),
                     w_req_i && (w_nexthop_addr_i == S_ADDR),
                     n_req_i && (n_nexthop_addr_i == S_ADDR)};

  assign w_has_credit = (r_credits != '0);
  assign w_locked     = (r_state == ST_LOCKED);
  assign w_flit_valid = w_locked && w_req[r_owner] && w_has_credit;
  assign w_pkt_end    = w_flit_valid && w_tail[r_owner];

  // Round-robin winner: first desiring input scanning cyclically from r_ptr
  always_comb begin
    w_winner       = '0;
    w_winner_found = 1'b0;
    w_idx          = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_winner_found && w_desire[w_idx]) begin
        w_winner       = w_idx;
        w_winner_found = 1'b1;
      end
    end
  end

  // Credit counter next value; a return at full count is dropped
  always_comb begin
    w_credits_nxt = r_credits;
    case ({w_flit_valid, s_credit_return_i})
      2'b10:   w_credits_nxt = r_credits - 1'b1;
      2'b01:   w_credits_nxt = (r_credits == L_CREDITS) ? r_credits : r_credits + 1'b1;
      default: w_credits_nxt = r_credits;
    endcase
  end

  // FSM next state: arbitrate in IDLE, release lock after the tail transfer
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_rr_pulse_nxt = w_pkt_end;
    case (r_state)
      ST_IDLE: begin
        if (w_winner_found && w_has_credit) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_winner;
        end
      end
      ST_LOCKED: begin
        if (w_pkt_end) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_owner + 2'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, owner, pointer, credits and rotate-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_credits  <= L_CREDITS;
      r_rr_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_credits  <= w_credits_nxt;
      r_rr_pulse <= w_rr_pulse_nxt;
    end
  end

  // Outputs decode only registered state, so reset clears them immediately
  assign s_busy_o          = w_locked;
  assign s_grant_n_o       = w_locked && (r_owner == 2'd0);
  assign s_grant_w_o       = w_locked && (r_owner == 2'd1);
  assign s_grant_e_o       = w_locked && (r_owner == 2'd2);
  assign s_grant_l_o       = w_locked && (r_owner == 2'd3);
  assign s_xbar_sel_o      = w_locked ? ({1'b0, r_owner} + 3'd1) : '0;
  assign s_flit_valid_o    = w_flit_valid;
  assign rr_change_order_o = r_rr_pulse;
  assign s_credits_o       = r_credits;

endmodule

// File: tb/tb_s_port_arbiter_ctrl.sv
// Self-checking bench for s_port_arbiter_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the south-port rules.
module tb_s_port_arbiter_ctrl;

  localparam int CREDITS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, tail;
  logic [2:0] nh [4];
  logic       ret;

  logic       g_n, g_w, g_e, g_l;
  logic [2:0] sel;
  logic       fv, pulse, busy;
  logic [2:0] cred;
  logic [3:0] grants;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit m_locked;
  int m_owner, m_ptr, m_cred;
  bit m_pulse;

  assign grants = {g_l, g_e, g_w, g_n};

  always #5 clk = ~clk;

  s_port_arbiter_ctrl #(.S_ADDR(3'd1), .CREDITS(4), .CW(3)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .n_req_i           (req[0]),
    .w_req_i           (req[1]),
    .e_req_i           (req[2]),
    .l_req_i           (req[3]),
    .n_nexthop_addr_i  (nh[0]),
    .w_nexthop_addr_i  (nh[1]),
    .e_nexthop_addr_i  (nh[2]),
    .l_nexthop_addr_i  (nh[3]),
    .n_tail_i          (tail[0]),
    .w_tail_i          (tail[1]),
    .e_tail_i          (tail[2]),
    .l_tail_i          (tail[3]),
    .s_credit_return_i (ret),
    .s_grant_n_o       (g_n),
    .s_grant_w_o       (g_w),
    .s_grant_e_o       (g_e),
    .s_grant_l_o       (g_l),
    .s_xbar_sel_o      (sel),
    .s_flit_valid_o    (fv),
    .rr_change_order_o (pulse),
    .s_credits_o       (cred),
    .s_busy_o          (busy)
  );

  task automatic clear_inputs();
    req  = '0;
    tail = '0;
    ret  = 1'b0;
    for (int i = 0; i < 4; i++) nh[i] = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 with the DUT in IDLE; the next interval is cycle 0
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cred   = CREDITS;
    m_pulse  = 1'b0;
  endtask

  // Advance the reference model by one clock using the current inputs
  task automatic model_step();
    bit mfv, endp, found;
    int c, idx;
    mfv  = m_locked && req[m_owner] && (m_cred > 0);
    endp = mfv && tail[m_owner];
    c = m_cred - int'(mfv) + int'(ret);
    if (c > CREDITS) c = CREDITS;
    if (m_locked) begin
      if (endp) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % 4;
      end
    end else if (m_cred > 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!found && req[idx] && nh[idx] == 3'd1) begin
          found    = 1'b1;
          m_locked = 1'b1;
          m_owner  = idx;
        end
      end
    end
    m_pulse = endp;
    m_cred  = c;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_checks++; if (grants !== 4'b0000) $display("FAIL reset_grants got=%b exp=0000", grants); else n_pass++;
    n_checks++; if (sel !== 3'd0) $display("FAIL reset_sel got=%0d exp=0", sel); else n_pass++;
    n_checks++; if (fv !== 1'b0) $display("FAIL reset_fv got=%b exp=0", fv); else n_pass++;
    n_checks++; if (pulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", pulse); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (cred !== 3'd4) $display("FAIL reset_credits got=%0d exp=4", cred); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req[1] = 1'b1; nh[1] = 3'd1; tail[1] = 1'b1;
    #2;
    n_checks++; if (grants !== 4'b0000) $display("FAIL single_c0_grant got=%b exp=0000", grants); else n_pass++;
    tick(); #2;
    n_checks++; if (grants !== 4'b0010) $display("FAIL single_c1_grant got=%b exp=0010", grants); else n_pass++;
    n_checks++; if (sel !== 3'd2) $display("FAIL single_c1_sel got=%0d exp=2", sel); else n_pass++;
    n_checks++; if (fv !== 1'b1) $display("FAIL single_c1_fv got=%b exp=1", fv); else n_pass++;
    tick();
    req = 4'b0101; nh[0] = 3'd1; nh[2] = 3'd1; tail = 4'b0101;
    #2;
    n_checks++; if (grants !== 4'b0000) $display("FAIL single_c2_grant got=%b exp=0000", grants); else n_pass++;
    n_checks++; if (pulse !== 1'b1) $display("FAIL single_c2_pulse got=%b exp=1", pulse); else n_pass++;
    n_checks++; if (cred !== 3'd3) $display("FAIL single_c2_credits got=%0d exp=3", cred); else n_pass++;
    tick(); #2;
    n_checks++; if (grants !== 4'b0100) $display("FAIL single_ptr_e got=%b exp=0100", grants); else n_pass++;
  endtask

  task automatic test_round_robin();
    int pulses = 0;
    logic [2:0] exp_sel;
    do_reset();
    req = 4'b1111; tail = 4'b1111;
    for (int i = 0; i < 4; i++) nh[i] = 3'd1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #2;
      exp_sel = ((cyc % 2) == 1 && cyc <= 7) ? 3'((cyc + 1) / 2) : 3'd0;
      n_checks++; if (sel !== exp_sel) $display("FAIL rr_sel_c%0d got=%0d exp=%0d", cyc, sel, exp_sel); else n_pass++;
      if (pulse === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 4) $display("FAIL rr_pulses got=%0d exp=4", pulses); else n_pass++;
    n_checks++; if (cred !== 3'd0) $display("FAIL rr_credits got=%0d exp=0", cred); else n_pass++;
  endtask

  task automatic test_wormhole();
    do_reset();
    req[2] = 1'b1; nh[2] = 3'd1; tail[2] = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 1) begin req[0] = 1'b1; nh[0] = 3'd1; tail[0] = 1'b1; end
      if (cyc == 3) tail[2] = 1'b1;
      if (cyc == 4) req[2] = 1'b0;
      #2;
      if (cyc >= 1 && cyc <= 3) begin
        n_checks++; if (sel !== 3'd3) $display("FAIL worm_sel_c%0d got=%0d exp=3", cyc, sel); else n_pass++;
        n_checks++; if (fv !== 1'b1) $display("FAIL worm_fv_c%0d got=%b exp=1", cyc, fv); else n_pass++;
      end
      if (cyc == 4) begin
        n_checks++; if (grants !== 4'b0000) $display("FAIL worm_c4_grant got=%b exp=0000", grants); else n_pass++;
        n_checks++; if (pulse !== 1'b1) $display("FAIL worm_c4_pulse got=%b exp=1", pulse); else n_pass++;
      end
      if (cyc == 5) begin
        n_checks++; if (grants !== 4'b0001) $display("FAIL worm_c5_grant got=%b exp=0001", grants); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_credit_stall();
    bit         exp_fv;
    logic [2:0] exp_cred;
    do_reset();
    req[0] = 1'b1; nh[0] = 3'd1; tail[0] = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      ret = (cyc == 6);
      #2;
      exp_fv = (cyc <= 4) || (cyc == 7);
      case (cyc)
        1: exp_cred = 3'd4; 2: exp_cred = 3'd3; 3: exp_cred = 3'd2; 4: exp_cred = 3'd1;
        7: exp_cred = 3'd1; default: exp_cred = 3'd0;
      endcase
      n_checks++; if (fv !== exp_fv) $display("FAIL stall_fv_c%0d got=%b exp=%b", cyc, fv, exp_fv); else n_pass++;
      n_checks++; if (grants !== 4'b0001) $display("FAIL stall_grant_c%0d got=%b exp=0001", cyc, grants); else n_pass++;
      n_checks++; if (cred !== exp_cred) $display("FAIL stall_cred_c%0d got=%0d exp=%0d", cyc, cred, exp_cred); else n_pass++;
    end
  endtask

  task automatic test_filter_saturation();
    do_reset();
    req[3] = 1'b1; nh[3] = 3'd2; tail[3] = 1'b1; ret = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #2;
      n_checks++; if (grants !== 4'b0000) $display("FAIL filter_grant_c%0d got=%b exp=0000", cyc, grants); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL filter_busy_c%0d got=%b exp=0", cyc, busy); else n_pass++;
      n_checks++; if (cred !== 3'd4) $display("FAIL sat_cred_c%0d got=%0d exp=4", cyc, cred); else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req[0] = 1'b1; nh[0] = 3'd1; tail[0] = 1'b1;
    tick(); tick();
    req[0] = 1'b0; req[1] = 1'b1; nh[1] = 3'd1; tail[1] = 1'b0;
    tick(); #2;
    n_checks++; if (grants !== 4'b0010) $display("FAIL areset_pre_grant got=%b exp=0010", grants); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (grants !== 4'b0000) $display("FAIL areset_grant got=%b exp=0000", grants); else n_pass++;
    n_checks++; if (sel !== 3'd0) $display("FAIL areset_sel got=%0d exp=0", sel); else n_pass++;
    n_checks++; if (fv !== 1'b0) $display("FAIL areset_fv got=%b exp=0", fv); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (cred !== 3'd4) $display("FAIL areset_cred got=%0d exp=4", cred); else n_pass++;
    #2;
    rst_n = 1'b1;
    req[0] = 1'b1; nh[0] = 3'd1; tail[0] = 1'b1;
    tick(); #2;
    n_checks++; if (grants !== 4'b0001) $display("FAIL areset_n_first got=%b exp=0001", grants); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_grants;
    logic [2:0] exp_sel;
    bit         exp_fv;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]  = ($urandom_range(0, 1) == 1);
        nh[i]   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        tail[i] = ($urandom_range(0, 2) == 0);
      end
      ret = ($urandom_range(0, 1) == 1);
      #2;
      exp_grants = m_locked ? (4'b0001 << m_owner) : 4'b0000;
      exp_sel    = m_locked ? 3'(m_owner + 1) : 3'd0;
      exp_fv     = m_locked && req[m_owner] && (m_cred > 0);
      n_checks++; if (grants !== exp_grants) $display("FAIL rand_grant_c%0d got=%b exp=%b", cyc, grants, exp_grants); else n_pass++;
      n_checks++; if (sel !== exp_sel) $display("FAIL rand_sel_c%0d got=%0d exp=%0d", cyc, sel, exp_sel); else n_pass++;
      n_checks++; if (fv !== exp_fv) $display("FAIL rand_fv_c%0d got=%b exp=%b", cyc, fv, exp_fv); else n_pass++;
      n_checks++; if (pulse !== m_pulse) $display("FAIL rand_pulse_c%0d got=%b exp=%b", cyc, pulse, m_pulse); else n_pass++;
      n_checks++; if (cred !== 3'(m_cred)) $display("FAIL rand_cred_c%0d got=%0d exp=%0d", cyc, cred, m_cred); else n_pass++;
      n_checks++; if (busy !== m_locked) $display("FAIL rand_busy_c%0d got=%b exp=%b", cyc, busy, m_locked); else n_pass++;
      model_step();
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_filter_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
